instr_loader: RTL

Streams a program into the CPU's instruction memory before execution starts. The block sits directly upstream of the CPU: it accepts a byte stream over a valid/ready handshake and packs every three bytes into one 20-bit instruction word. It writes each word to consecutive instruction-memory addresses from 0, holding the CPU in reset until the last word is written. It then releases the CPU and reports completion.

---
 rtl/instr_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream instruction loader that holds the CPU in reset until imem is filled
// Packs three bytes per 20-bit word, writes consecutive addresses from 0, then releases the CPU.
module instr_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 20
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [ADDR_W:0]    i_word_count,
  input  logic               i_byte_valid,
  input  logic [7:0]         i_byte_data,
  output logic               o_byte_ready,
  output logic               o_imem_we,
  output logic [ADDR_W-1:0]  o_imem_addr,
  output logic [INSTR_W-1:0] o_imem_wdata,
  output logic               o_cpu_reset,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W:0]    r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_wdata;
  logic               r_err;

  logic               w_start_ok;
  logic               w_oversize;
  logic               w_xfer;
  logic               w_last;
  logic [ADDR_W:0]    w_cnt_start;
  logic [ADDR_W:0]    w_addr_inc;

  assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_oversize  = i_word_count > DEPTH;
  assign w_cnt_start = w_oversize ? DEPTH : i_word_count;
  // Compared at ADDR_W+1 bits so a full-depth load terminates when addr wraps to 0
  assign w_addr_inc  = {1'b0, r_addr} + (ADDR_W+1)'(1);
  assign w_last      = (w_addr_inc == r_cnt);
  assign w_xfer      = i_byte_valid && o_byte_ready;

  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_err        = r_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    o_byte_ready = 1'b0;
    o_imem_we    = 1'b0;
    o_cpu_reset  = 1'b1;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next = (w_cnt_start == '0) ? S_DONE : S_B0;
      end
      S_B0: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (w_xfer) w_next = S_B1;
      end
      S_B1: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (w_xfer) w_next = S_B2;
      end
      S_B2: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (w_xfer) w_next = S_WRITE;
      end
      S_WRITE: begin
        o_imem_we = 1'b1;
        o_busy    = 1'b1;
        w_next    = w_last ? S_DONE : S_B0;
      end
      S_DONE: begin
        o_cpu_reset = 1'b0;
        o_done      = 1'b1;
        if (w_start_ok) w_next = (w_cnt_start == '0) ? S_DONE : S_B0;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_cnt  <= w_cnt_start;
        r_addr <= '0;
        r_err  <= w_oversize;
      end
      if (w_xfer) begin
        case (r_state)
          S_B0: begin
            r_wdata[19:16] <= i_byte_data[3:0];
            if (|i_byte_data[7:4]) r_err <= 1'b1;
          end
          S_B1:    r_wdata[15:8] <= i_byte_data;
          S_B2:    r_wdata[7:0]  <= i_byte_data;
          default: ;
        endcase
      end
      if (r_state == S_WRITE) r_addr <= w_addr_inc[ADDR_W-1:0];
    end
  end

endmodule
